// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// Sequences camera capture into the 176x144 RGB332 frame buffer, owns the
// single frame-buffer write port (camera has fixed priority over the overlay
// writer) and produces a red/blue/none verdict for every stored frame.
// Optional build macro FRAME_CAPTURE_CTRL_DECIM_EN adds a decim_en input that
// stores only even-row/even-column pixels as a quarter-size image.
module frame_capture_ctrl #(
    parameter int H_PIXELS = 176,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 15,
    parameter int CNT_W    = 15,
    parameter int MIN_PIX  = 100
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              cap_req,
    input  logic              cont_en,
`ifdef FRAME_CAPTURE_CTRL_DECIM_EN
    input  logic              decim_en,
`endif
    input  logic              vsync,
    input  logic              pix_wen,
    input  logic [ADDR_W-1:0] pix_x,
    input  logic [ADDR_W-1:0] pix_y,
    input  logic [7:0]        pix_data,
    input  logic              ovl_req,
    input  logic [ADDR_W-1:0] ovl_addr,
    input  logic [7:0]        ovl_data,
    output logic              ovl_gnt,
    output logic              fb_wen,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        color
);

    localparam logic [ADDR_W-1:0] H_LIM   = ADDR_W'(H_PIXELS);
    localparam logic [ADDR_W-1:0] V_LIM   = ADDR_W'(V_LINES);
    localparam logic [CNT_W-1:0]  MIN_CNT = CNT_W'(MIN_PIX);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic              armed_nxt;
    logic              clr_cnt;

    logic              vs_d;
    logic              vs_rise;

    logic              in_range;
    logic              pix_keep;
    logic              cam_wr;
    logic [ADDR_W-1:0] cam_addr;

    logic [2:0]        pix_r;
    logic [2:0]        pix_g;
    logic [1:0]        pix_b;
    logic              is_red;
    logic              is_blue;

    logic [CNT_W-1:0]  red_cnt;
    logic [CNT_W-1:0]  blue_cnt;
    logic [CNT_W-1:0]  none_cnt;

    logic [1:0]        verdict;
    logic [1:0]        color_q;

    // vsync rising edge is found against the previous-cycle copy of vsync
    assign vs_rise = vsync & ~vs_d;

    assign in_range = (pix_x < H_LIM) && (pix_y < V_LIM);

`ifdef FRAME_CAPTURE_CTRL_DECIM_EN
    localparam logic [ADDR_W-1:0] H_HALF = ADDR_W'(H_PIXELS / 2);

    // decimated capture keeps even rows/columns packed into a half-width image
    always_comb begin
        pix_keep = 1'b1;
        cam_addr = pix_y * H_LIM + pix_x;
        if (decim_en) begin
            pix_keep = ~pix_x[0] & ~pix_y[0];
            cam_addr = (pix_y >> 1) * H_HALF + (pix_x >> 1);
        end
    end
`else
    assign pix_keep = 1'b1;
    assign cam_addr = pix_y * H_LIM + pix_x;
`endif

    // a camera write is issued only for in-range pixels while a frame is stored
    assign cam_wr = (state == CAPTURE) && pix_wen && in_range && pix_keep;

    // overlay only gets the port in cycles the camera leaves free; no grant is
    // given while reset is held because the write register would be cleared
    assign ovl_gnt = reset && ovl_req && !cam_wr;

    assign pix_r   = pix_data[7:5];
    assign pix_g   = pix_data[4:2];
    assign pix_b   = pix_data[1:0];
    assign is_red  = (pix_r > 3'd4) && (pix_g < 3'd4) && (pix_b < 2'd2);
    assign is_blue = (pix_r < 3'd4) && (pix_g < 3'd4) && (pix_b > 2'd2);

    // next-state, arming and counter-clear decisions for the capture sequencer
    always_comb begin
        state_nxt = state;
        armed_nxt = armed;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (cap_req) begin
                    armed_nxt = 1'b1;
                end
                if ((armed || cap_req || cont_en) && vs_rise) begin
                    state_nxt = CAPTURE;
                    clr_cnt   = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                armed_nxt = 1'b0;
                if (cont_en) begin
                    state_nxt = CAPTURE;
                    clr_cnt   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                armed_nxt = 1'b0;
            end
        endcase
    end

    // state register, arm flag and the vsync history bit
    always_ff @(posedge pclk) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= armed_nxt;
            vs_d  <= vsync;
        end
    end

    // registered write port: camera wins, overlay takes any free cycle
    always_ff @(posedge pclk) begin
        if (!reset) begin
            fb_wen  <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (cam_wr) begin
            fb_wen  <= 1'b1;
            fb_addr <= cam_addr;
            fb_data <= pix_data;
        end else if (ovl_gnt) begin
            fb_wen  <= 1'b1;
            fb_addr <= ovl_addr;
            fb_data <= ovl_data;
        end else begin
            fb_wen  <= 1'b0;
        end
    end

    // saturating per-class counters of stored camera pixels, restarted per frame
    always_ff @(posedge pclk) begin
        if (!reset || clr_cnt) begin
            red_cnt  <= '0;
            blue_cnt <= '0;
            none_cnt <= '0;
        end else if (cam_wr) begin
            if (is_red) begin
                if (red_cnt != CNT_MAX) begin
                    red_cnt <= red_cnt + 1'b1;
                end
            end else if (is_blue) begin
                if (blue_cnt != CNT_MAX) begin
                    blue_cnt <= blue_cnt + 1'b1;
                end
            end else begin
                if (none_cnt != CNT_MAX) begin
                    none_cnt <= none_cnt + 1'b1;
                end
            end
        end
    end

    // a colour wins only if it beats both other classes and reaches MIN_PIX
    always_comb begin
        verdict = 2'd0;
        if ((red_cnt > blue_cnt) && (red_cnt > none_cnt) && (red_cnt >= MIN_CNT)) begin
            verdict = 2'd1;
        end else if ((blue_cnt > red_cnt) && (blue_cnt > none_cnt) && (blue_cnt >= MIN_CNT)) begin
            verdict = 2'd2;
        end
    end

    // the verdict is latched while DONE so it holds until the next stored frame
    always_ff @(posedge pclk) begin
        if (!reset) begin
            color_q <= 2'd0;
        end else if (state == DONE) begin
            color_q <= verdict;
        end
    end

    assign busy       = (state == CAPTURE);
    assign frame_done = (state == DONE);
    assign color      = (state == DONE) ? verdict : color_q;

endmodule
